// File: rtl/master_bus_requester_if.sv
// Bundle between one master core, its bus requester front end and the two-master arbiter.
// The master modport is the requester's view; slave is the core/arbiter side.
interface master_bus_requester_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_slave;
   logic       m_request;
   logic       m_slave_sel;
   logic       m_grant;
   logic       arbiter_busy;
   logic       trans_done;
   logic       bus_owned;
   logic       split_wait;
   logic       xfer_done;
   logic       xfer_err;

   modport master (
      input  cmd_valid, cmd_slave, m_grant, arbiter_busy, trans_done,
      output cmd_ready, m_request, m_slave_sel, bus_owned, split_wait, xfer_done, xfer_err
   );

   modport slave (
      output cmd_valid, cmd_slave, m_grant, arbiter_busy, trans_done,
      input  cmd_ready, m_request, m_slave_sel, bus_owned, split_wait, xfer_done, xfer_err
   );
endinterface

// File: rtl/master_bus_requester.sv
// Master-side arbiter front end: requests the bus, shifts the target slave id out MSB-first,
// then tracks grant, split suspension and completion, reporting done/error to the core.
module master_bus_requester #(
   parameter int unsigned GRANT_TIMEOUT = 16,
   parameter int unsigned MAX_RETRY     = 2,
   parameter int unsigned SPLIT_TIMEOUT = 64
) (
   input logic                    sys_clk,
   input logic                    sys_rst,
   master_bus_requester_if.master bus
);

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned RETRY_W = 3;
   localparam int unsigned STATE_W = 3;

   localparam logic [CNT_W-1:0]   GNT_LAST  = CNT_W'(GRANT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   SPL_LAST  = CNT_W'(SPLIT_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] S_ARM   = 3'd1;
   localparam logic [STATE_W-1:0] S_REQ   = 3'd2;
   localparam logic [STATE_W-1:0] S_SEL   = 3'd3;
   localparam logic [STATE_W-1:0] S_WAIT  = 3'd4;
   localparam logic [STATE_W-1:0] S_XFER  = 3'd5;
   localparam logic [STATE_W-1:0] S_SPLIT = 3'd6;
   localparam logic [STATE_W-1:0] S_DONE  = 3'd7;

   logic [STATE_W-1:0] r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [RETRY_W-1:0] r_retry;
   logic [1:0]         r_slave;
   logic               r_cmd_ready;
   logic               r_request;
   logic               r_slave_sel;
   logic               r_bus_owned;
   logic               r_split_wait;
   logic               r_xfer_done;
   logic               r_xfer_err;

   logic [STATE_W-1:0] w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [RETRY_W-1:0] w_retry_nxt;
   logic [1:0]         w_slave_nxt;
   logic               w_err_nxt;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [RETRY_W-1:0] w_retry_inc;

   // Saturating increments; neither counter may wrap.
   assign w_cnt_inc   = (r_cnt == '1)   ? r_cnt   : r_cnt + CNT_W'(1);
   assign w_retry_inc = (r_retry == '1) ? r_retry : r_retry + RETRY_W'(1);

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;
      w_slave_nxt = r_slave;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid && r_cmd_ready) begin
               w_slave_nxt = bus.cmd_slave;
               w_retry_nxt = '0;
               w_state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            if (!bus.arbiter_busy) w_state_nxt = S_REQ;
         end
         S_REQ: w_state_nxt = S_SEL;
         S_SEL: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.m_grant) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_XFER;
            end else if (r_cnt >= GNT_LAST) begin
               w_cnt_nxt = '0;
               if (r_retry < RETRY_MAX) begin
                  w_retry_nxt = w_retry_inc;
                  w_state_nxt = S_ARM;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         // Completion takes priority over a simultaneous grant drop.
         S_XFER: begin
            if (bus.trans_done) begin
               w_state_nxt = S_DONE;
            end else if (!bus.m_grant) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_SPLIT;
            end
         end
         S_SPLIT: begin
            if (bus.m_grant) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_XFER;
            end else if (r_cnt >= SPL_LAST) begin
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_cnt        <= '0;
         r_retry      <= '0;
         r_slave      <= '0;
         r_cmd_ready  <= 1'b1;
         r_request    <= 1'b0;
         r_slave_sel  <= 1'b0;
         r_bus_owned  <= 1'b0;
         r_split_wait <= 1'b0;
         r_xfer_done  <= 1'b0;
         r_xfer_err   <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_retry      <= w_retry_nxt;
         r_slave      <= w_slave_nxt;
         r_cmd_ready  <= (w_state_nxt == S_IDLE);
         r_request    <= (w_state_nxt == S_REQ);
         r_slave_sel  <= ((w_state_nxt == S_REQ) && w_slave_nxt[1]) ||
                         ((w_state_nxt == S_SEL) && w_slave_nxt[0]);
         r_bus_owned  <= (w_state_nxt == S_XFER);
         r_split_wait <= (w_state_nxt == S_SPLIT);
         r_xfer_done  <= (w_state_nxt == S_DONE);
         r_xfer_err   <= w_err_nxt;
      end
   end

   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.m_request   = r_request;
   assign bus.m_slave_sel = r_slave_sel;
   assign bus.bus_owned   = r_bus_owned;
   assign bus.split_wait  = r_split_wait;
   assign bus.xfer_done   = r_xfer_done;
   assign bus.xfer_err    = r_xfer_err;

endmodule

// File: tb/tb_master_bus_requester.sv
// Directed bench for master_bus_requester: a table of whole-command scenarios with
// hand-computed cycle timings, plus reset-abort sequences.
module tb_master_bus_requester;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b0;

   master_bus_requester_if bus ();

   master_bus_requester #(
      .GRANT_TIMEOUT(16),
      .MAX_RETRY    (2),
      .SPLIT_TIMEOUT(64)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus    (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // t counts falling edges after the accepting rising edge; inputs set at t apply to rising edge t.
   typedef struct {
      string      name;
      logic [1:0] slave;
      int         busy;       // arbiter_busy high for edges 1..busy
      int         gnt_t;      // grant high from edge gnt_t ...
      int         drop_t;     // ... except edges drop_t .. drop_t+drop_n-1
      int         drop_n;
      int         td_t;       // trans_done pulse edge (0 = none)
      int         td_x_t;     // extra trans_done pulse expected to be ignored (0 = none)
      int         exp_req_t;
      logic [1:0] exp_sel;
      int         exp_req_n;
      int         exp_own;
      int         exp_split;
      int         exp_done_t;
      logic       exp_err;
   } vec_t;

   int tests = 0;
   int fails = 0;
   vec_t vecs[10];

   function automatic vec_t mk(input string n, input logic [1:0] s, input int b, input int g,
                               input int dt, input int dn, input int td, input int tdx,
                               input int rq, input logic [1:0] sl, input int rn, input int ow,
                               input int sp, input int dn_t, input logic er);
      vec_t v;
      v.name = n; v.slave = s; v.busy = b; v.gnt_t = g; v.drop_t = dt; v.drop_n = dn;
      v.td_t = td; v.td_x_t = tdx; v.exp_req_t = rq; v.exp_sel = sl; v.exp_req_n = rn;
      v.exp_own = ow; v.exp_split = sp; v.exp_done_t = dn_t; v.exp_err = er;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.cmd_valid    = 1'b0;
      bus.cmd_slave    = 2'b00;
      bus.m_grant      = 1'b0;
      bus.arbiter_busy = 1'b0;
      bus.trans_done   = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int         req_t    = -1;
      int         last_req = -10;
      int         req_n    = 0;
      int         own      = 0;
      int         spl      = 0;
      int         done_t   = -1;
      int         done_n   = 0;
      int         stray    = 0;
      int         cr1      = -1;
      int         rdy      = -1;
      logic [1:0] sel      = 2'b00;
      logic       err      = 1'b0;
      @(negedge sys_clk);
      bus.cmd_valid    = 1'b1;
      bus.cmd_slave    = v.slave;
      bus.arbiter_busy = (v.busy > 0);
      bus.m_grant      = 1'b0;
      bus.trans_done   = 1'b0;
      for (int t = 1; t <= v.exp_done_t + 2 && t <= 200; t++) begin
         @(negedge sys_clk);
         if (t == 1) cr1 = int'(bus.cmd_ready);
         if (bus.m_request) begin
            req_n++;
            last_req = t;
            if (req_t < 0) req_t = t;
         end
         if (t == last_req) begin
            if (t == req_t) sel[1] = bus.m_slave_sel;
         end else if (t == last_req + 1) begin
            if (last_req == req_t) sel[0] = bus.m_slave_sel;
         end else if (bus.m_slave_sel) begin
            stray++;
         end
         if (bus.bus_owned) own++;
         if (bus.split_wait) spl++;
         if (bus.split_wait && bus.bus_owned) stray++;
         if (bus.xfer_err && !bus.xfer_done) stray++;
         if (bus.xfer_done) begin
            done_n++;
            if (done_t < 0) begin
               done_t = t;
               err    = bus.xfer_err;
            end
         end
         if (t == v.exp_done_t + 1) rdy = int'(bus.cmd_ready);
         bus.cmd_valid    = 1'b0;
         bus.arbiter_busy = (t <= v.busy);
         bus.m_grant      = (t >= v.gnt_t) && !(t >= v.drop_t && t < v.drop_t + v.drop_n);
         bus.trans_done   = (t == v.td_t) || (t == v.td_x_t);
      end
      idle_inputs();
      chk({v.name, ".ready_drop"}, cr1, 0);
      chk({v.name, ".req_t"}, req_t, v.exp_req_t);
      chk({v.name, ".sel"}, int'(sel), int'(v.exp_sel));
      chk({v.name, ".req_n"}, req_n, v.exp_req_n);
      chk({v.name, ".owned_cycles"}, own, v.exp_own);
      chk({v.name, ".split_cycles"}, spl, v.exp_split);
      chk({v.name, ".done_t"}, done_t, v.exp_done_t);
      chk({v.name, ".done_n"}, done_n, 1);
      chk({v.name, ".err"}, int'(err), int'(v.exp_err));
      chk({v.name, ".ready_back"}, rdy, 1);
      chk({v.name, ".stray_out"}, stray, 0);
   endtask

   // Reset asserted mid-cycle while m_request (mode 0) or bus_owned (mode 1) is high.
   task automatic reset_abort(input int mode);
      string nm;
      int    hit  = 0;
      int    done = 0;
      nm = (mode == 0) ? "rst_req" : "rst_xfer";
      @(negedge sys_clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_slave = 2'b11;
      for (int t = 1; t <= 20 && hit == 0; t++) begin
         @(negedge sys_clk);
         bus.cmd_valid = 1'b0;
         bus.m_grant   = (t >= 4);
         if ((mode == 0 && bus.m_request) || (mode == 1 && bus.bus_owned)) hit = 1;
      end
      chk({nm, ".reached"}, hit, 1);
      #2 sys_rst = 1'b0;
      #1;
      chk({nm, ".bus_owned"}, int'(bus.bus_owned), 0);
      chk({nm, ".m_request"}, int'(bus.m_request), 0);
      chk({nm, ".cmd_ready"}, int'(bus.cmd_ready), 1);
      chk({nm, ".others"}, int'({bus.m_slave_sel, bus.split_wait, bus.xfer_done, bus.xfer_err}), 0);
      idle_inputs();
      @(negedge sys_clk);
      sys_rst = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(negedge sys_clk);
         if (bus.xfer_done || !bus.cmd_ready) done++;
      end
      chk({nm, ".quiet_after"}, done, 0);
   endtask

   initial begin
      idle_inputs();
      vecs[0] = mk("basic_11",      2'b11, 0,   5,  0,   0,  9,  0,  2, 2'b11, 1, 4,  0, 10, 1'b0);
      vecs[1] = mk("ser_10",        2'b10, 0,   4,  0,   0,  5,  0,  2, 2'b10, 1, 1,  0,  6, 1'b0);
      vecs[2] = mk("ser_01",        2'b01, 0,   4,  0,   0,  6,  0,  2, 2'b01, 1, 2,  0,  7, 1'b0);
      vecs[3] = mk("busy_hold",     2'b00, 5,   9,  0,   0, 10,  0,  7, 2'b00, 1, 1,  0, 11, 1'b0);
      vecs[4] = mk("split6",        2'b11, 0,   5,  7,   6, 15, 10,  2, 2'b11, 1, 4,  6, 16, 1'b0);
      vecs[5] = mk("gnt_timeout",   2'b10, 0, 999,  0,   0,  0,  0,  2, 2'b10, 3, 0,  0, 58, 1'b1);
      vecs[6] = mk("gnt_in_arm",    2'b01, 0,  20, 21, 999,  0,  0,  2, 2'b01, 3, 0,  0, 58, 1'b1);
      vecs[7] = mk("early_grant",   2'b01, 0,   1,  0,   0,  5,  0,  2, 2'b01, 1, 1,  0,  6, 1'b0);
      vecs[8] = mk("split_timeout", 2'b11, 0,   4,  6, 999,  0, 30,  2, 2'b11, 1, 2, 64, 71, 1'b1);
      vecs[9] = mk("done_wins",     2'b00, 0,   4,  6, 999,  6,  0,  2, 2'b00, 1, 2,  0,  7, 1'b0);

      @(negedge sys_clk);
      @(negedge sys_clk);
      chk("reset.cmd_ready", int'(bus.cmd_ready), 1);
      chk("reset.m_request", int'(bus.m_request), 0);
      chk("reset.m_slave_sel", int'(bus.m_slave_sel), 0);
      chk("reset.bus_owned", int'(bus.bus_owned), 0);
      chk("reset.split_wait", int'(bus.split_wait), 0);
      chk("reset.xfer_done", int'(bus.xfer_done), 0);
      chk("reset.xfer_err", int'(bus.xfer_err), 0);
      sys_rst = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      reset_abort(0);
      run_vec(mk("after_rst_req", 2'b10, 0, 4, 0, 0, 5, 0, 2, 2'b10, 1, 1, 0, 6, 1'b0));
      reset_abort(1);
      run_vec(mk("after_rst_xfer", 2'b11, 0, 5, 0, 0, 9, 0, 2, 2'b11, 1, 4, 0, 10, 1'b0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
